tx_uart: RTL and testbench
==========================

// Module: tx_uart
// PURPOSE
//   UART transmitter; the TX half of the TP2 UART, pairing with the receive path.
//   Serializes a parallel byte into 1 start bit, NB_DATA data bits (LSB first) and
//   N_STOP_BITS stop bits. Timing comes from a 16x-oversampling baud-tick enable.
//   Sits between the interface/ALU control FSM and the physical TX line.
// PARAMETERS
//   NB_DATA      8   data bits per frame
//   N_TICKS      16  i_tick pulses per bit period (same oversampling as the receiver)
//   N_STOP_BITS  2   stop bits per frame
//   NB_COUNT     5   tick counter width; must hold N_TICKS*N_STOP_BITS-1
//   NB_STATE     2   state register width
// PORTS
//   i_clock         in   1        system clock, all logic on posedge
//   i_reset         in   1        asynchronous, active-high reset
//   i_tick          in   1        baud-tick enable, 1-cycle pulse, N_TICKS per bit
//   i_tx_start      in   1        request: send i_data (level or pulse)
//   i_data          in   NB_DATA  byte to send; sampled only when a request is accepted
//   o_tx            out  1        serial line, idle high, registered
//   o_busy          out  1        high from acceptance until the frame is finished
//   o_tx_done_tick  out  1        1-clock pulse at end of last stop bit
// BEHAVIOUR
//   Reset (async, any state): state=IDLE, o_tx=1, o_busy=0, o_tx_done_tick=0,
//     counters=0, shift register=0. On release, resume at the next posedge.
//   FSM states: IDLE, START, DATA, STOP.
//   IDLE: o_tx=1. i_tx_start=1 at a posedge (independent of i_tick) -> latch
//     i_data into shreg, tick_cnt=0, bit_cnt=0, go START.
//     o_tx=0 and o_busy=1 from the next cycle (1-clock latency).
//   START: o_tx=0. On each i_tick: if tick_cnt==N_TICKS-1 -> tick_cnt=0, go DATA;
//     else tick_cnt+1.
//   DATA: o_tx=shreg[0]. On i_tick with tick_cnt==N_TICKS-1: tick_cnt=0,
//     shreg>>=1. If bit_cnt==NB_DATA-1, go STOP; else bit_cnt+1.
//   STOP: o_tx=1. On i_tick with tick_cnt==N_TICKS*N_STOP_BITS-1: go IDLE,
//     o_tx_done_tick=1 for exactly that one clock, o_busy=0 in the same cycle.
//   Counters advance only on i_tick; cycles without i_tick hold all state.
//   Each bit lasts exactly N_TICKS i_tick pulses (stop: N_TICKS*N_STOP_BITS),
//     counted from the first i_tick after entering the state.
//   Frame = (1+NB_DATA+N_STOP_BITS)*N_TICKS ticks (176 at defaults).
//   i_tx_start is ignored outside IDLE. No queuing. Changes to i_data
//     mid-frame do not affect the frame.
//   If i_tx_start is high in the cycle o_tx_done_tick pulses (state now IDLE),
//     it is accepted at that edge. Back-to-back frames then have no idle gap
//     beyond one clock.
//   Holding i_tx_start high sends frames continuously, latching i_data each time.
//   Reset mid-frame: the frame is truncated; o_tx returns high immediately and
//     no done pulse is produced.
//   State encoding is 2 bits. Unreachable encodings go to IDLE.
// TESTING
//   T1: i_tick every cycle, send 0x55 -> o_tx = 0 (16 cyc), then 1,0,1,0,1,0,1,0
//       (16 cyc each), then 1 (32 cyc); done pulse at cycle 176; o_busy high 176 cyc.
//   T2: i_tick every 4th cycle, send 0xA3 -> every bit held 64 clocks; LSB first
//       pattern 1,1,0,0,0,1,0,1; total busy 704 clocks.
//   T3: send 0x0F, pulse i_tx_start with 0xFF at tick 40 -> ignored; line shows 0x0F
//       only; one done pulse.
//   T4: i_tx_start held high, i_data 0x12 then 0x34 -> two contiguous frames, second
//       start bit begins 1 clock after first done pulse; two done pulses.
//   T5: assert i_reset asynchronously mid-DATA of 0xC3 (between clock edges) ->
//       o_tx=1 before the next edge, o_busy=0, no done pulse; next send of 0x3C is
//       correct.
//   T6: loopback o_tx->rx_uart i_rx sharing i_tick, bytes 0x00,0xFF,0xA5,0x5A ->
//       each received byte equals the sent byte, one rx done per tx done.

Source files
------------

// File: rtl/tx_uart.sv
// UART transmitter: start bit, NB_DATA data bits (LSB first), N_STOP_BITS stop bits,
// paced by a 16x-oversampling baud-tick enable. Outputs are all registered.
module tx_uart #(
  parameter int unsigned NB_DATA     = 8,
  parameter int unsigned N_TICKS     = 16,
  parameter int unsigned N_STOP_BITS = 2,
  parameter int unsigned NB_COUNT    = 5,
  parameter int unsigned NB_STATE    = 2
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_tick,
  input  logic               i_tx_start,
  input  logic [NB_DATA-1:0] i_data,
  output logic               o_tx,
  output logic               o_busy,
  output logic               o_tx_done_tick
);

  localparam int unsigned NbBit = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;

  localparam logic [NB_COUNT-1:0] LastTick = NB_COUNT'(N_TICKS - 1);
  localparam logic [NB_COUNT-1:0] LastStop = NB_COUNT'(N_TICKS * N_STOP_BITS - 1);
  localparam logic [NbBit-1:0]    LastBit  = NbBit'(NB_DATA - 1);

  typedef enum logic [NB_STATE-1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } state_e;

  state_e              state_q, state_d;
  logic [NB_COUNT-1:0] tick_cnt_q, tick_cnt_d;
  logic [NbBit-1:0]    bit_cnt_q, bit_cnt_d;
  logic [NB_DATA-1:0]  shreg_q, shreg_d;
  logic                tx_q, tx_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    done_d     = 1'b0;

    case (state_q)
      StIdle: begin
        if (i_tx_start) begin
          shreg_d    = i_data;
          tick_cnt_d = '0;
          bit_cnt_d  = '0;
          state_d    = StStart;
        end
      end
      StStart: begin
        if (i_tick) begin
          if (tick_cnt_q == LastTick) begin
            tick_cnt_d = '0;
            state_d    = StData;
          end else begin
            tick_cnt_d = tick_cnt_q + NB_COUNT'(1);
          end
        end
      end
      StData: begin
        if (i_tick) begin
          if (tick_cnt_q == LastTick) begin
            tick_cnt_d = '0;
            shreg_d    = shreg_q >> 1;
            if (bit_cnt_q == LastBit) begin
              state_d = StStop;
            end else begin
              bit_cnt_d = bit_cnt_q + NbBit'(1);
            end
          end else begin
            tick_cnt_d = tick_cnt_q + NB_COUNT'(1);
          end
        end
      end
      StStop: begin
        if (i_tick) begin
          if (tick_cnt_q == LastStop) begin
            tick_cnt_d = '0;
            state_d    = StIdle;
            done_d     = 1'b1;
          end else begin
            tick_cnt_d = tick_cnt_q + NB_COUNT'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Line and busy are decoded from the next state so they register alongside it.
    case (state_d)
      StStart: tx_d = 1'b0;
      StData:  tx_d = shreg_d[0];
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= StIdle;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign o_tx           = tx_q;
  assign o_busy         = busy_q;
  assign o_tx_done_tick = done_q;

endmodule

// File: tb/tb_tx_uart.sv
// Directed bench for tx_uart: samples line/busy/done every cycle at the falling edge
// and compares against the frame implied by the byte and the tick period.
module tb_tx_uart;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic       tx_start;
  logic [7:0] data;
  logic       tx;
  logic       busy;
  logic       done;

  int passed = 0;
  int total  = 0;

  tx_uart dut (
    .i_clock        (clk),
    .i_reset        (rst),
    .i_tick         (tick),
    .i_tx_start     (tx_start),
    .i_data         (data),
    .o_tx           (tx),
    .o_busy         (busy),
    .o_tx_done_tick (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int j, input logic [7:0] obs,
                       input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s at step %0d: got %0h expected %0h", tag, j, obs, exp);
  endtask

  // Frame bit index 0 = start, 1..8 = data LSB first, 9..10 = stop.
  function automatic logic frame_bit(input logic [7:0] d, input int pos);
    if (pos == 0) return 1'b0;
    if (pos <= 8) return d[pos-1];
    return 1'b1;
  endfunction

  // Ticks arrive on posedge j (j counted from the accept edge) whenever j % p == 0,
  // so every bit, the start bit included, spans exactly 16*p clocks.
  task automatic run_frame(input logic [7:0] d, input int p, input logic [7:0] next_d,
                           input bit hold, input bit inject, input bit already,
                           input int stop_j, input bit rx_chk);
    int         last;
    int         n;
    logic [7:0] rx;
    last = 176 * p + 1;
    rx   = 8'h00;
    if (!already) begin
      @(negedge clk);
      tx_start = 1'b1;
      data     = d;
      tick     = (p == 1);
    end
    for (int j = 1; j <= last; j++) begin
      @(negedge clk);
      n = (j - 1) / p;
      if (j == last) begin
        check("tx_end", j, {7'b0, tx}, 8'h01);
        check("busy_end", j, {7'b0, busy}, 8'h00);
        check("done_end", j, {7'b0, done}, 8'h01);
      end else begin
        check("tx_bit", j, {7'b0, tx}, {7'b0, frame_bit(d, n / 16)});
        check("busy_mid", j, {7'b0, busy}, 8'h01);
        check("done_mid", j, {7'b0, done}, 8'h00);
      end
      if (rx_chk && ((j - 1) % p == 0) && (n % 16 == 7) && (n / 16 >= 1) && (n / 16 <= 8))
        rx[n/16-1] = tx;
      tx_start = hold || (inject && j == 40);
      data     = (inject && j == 40) ? 8'hFF : next_d;
      tick     = (j % p == 0);
      if (j == stop_j) break;
    end
    if (rx_chk) check("rx_byte", 0, rx, d);
  endtask

  task automatic idle_check(input int cycles);
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      check("idle_tx", k, {7'b0, tx}, 8'h01);
      check("idle_busy", k, {7'b0, busy}, 8'h00);
      check("idle_done", k, {7'b0, done}, 8'h00);
      tx_start = 1'b0;
      tick     = 1'b1;
    end
  endtask

  initial begin
    rst      = 1'b1;
    tick     = 1'b0;
    tx_start = 1'b0;
    data     = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_tx", 0, {7'b0, tx}, 8'h01);
    check("rst_busy", 0, {7'b0, busy}, 8'h00);
    check("rst_done", 0, {7'b0, done}, 8'h00);
    rst = 1'b0;
    idle_check(3);

    // T1: tick every cycle, 0x55; i_data changed mid-frame must not matter
    run_frame(8'h55, 1, 8'hAA, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    idle_check(3);

    // T2: tick every 4th cycle, 0xA3
    run_frame(8'hA3, 4, 8'h00, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    idle_check(3);

    // T3: second request with 0xFF at tick 40 is ignored
    run_frame(8'h0F, 1, 8'h0F, 1'b0, 1'b1, 1'b0, 0, 1'b0);
    idle_check(3);

    // T4: start held high, two contiguous frames
    run_frame(8'h12, 1, 8'h34, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    run_frame(8'h34, 1, 8'h34, 1'b0, 1'b0, 1'b1, 0, 1'b0);
    idle_check(3);

    // T5: asynchronous reset while a zero data bit of 0xC3 is on the line
    run_frame(8'hC3, 1, 8'hC3, 1'b0, 1'b0, 1'b0, 50, 1'b0);
    check("pre_rst_tx", 50, {7'b0, tx}, 8'h00);
    #2;
    rst = 1'b1;
    #1;
    check("arst_tx", 0, {7'b0, tx}, 8'h01);
    check("arst_busy", 0, {7'b0, busy}, 8'h00);
    check("arst_done", 0, {7'b0, done}, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    idle_check(200);
    run_frame(8'h3C, 1, 8'h00, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    idle_check(2);

    // T6: mid-bit sampling receiver reconstructs each byte
    run_frame(8'h00, 2, 8'hFF, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    idle_check(1);
    run_frame(8'hFF, 2, 8'h00, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    idle_check(1);
    run_frame(8'hA5, 2, 8'h5A, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    idle_check(1);
    run_frame(8'h5A, 2, 8'hA5, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    idle_check(2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
